// File: rtl/pipeline_shift_chain.sv
// Decode-to-retire shift chain: stage 0 takes decode output (or a bubble on stall),
// later stages always shift. Define PIPE_PERF_COUNTERS_EN for bubble/kill counters.
module pipeline_shift_chain #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 3,
  parameter int STALL_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [STALL_W-1:0]             stall_in,
  input  logic                           clear_in,
  input  logic [DEPTH-1:0]               kill_mask,
  output logic                           in_ready,
  output logic [DEPTH-1:0]               out_valid,
  output logic [DEPTH*WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
`ifdef PIPE_PERF_COUNTERS_EN
  ,
  output logic [31:0]                    bubble_cnt,
  output logic [31:0]                    kill_cnt
`endif
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + OCC_W'(v[i]);
    return cnt;
  endfunction

  logic                          stall;
  logic                          load;
  logic                          s0_valid;
  logic [WIDTH-1:0]              s0_data;
  logic [DEPTH-1:0]              valid_q;
  logic [DEPTH-1:0][WIDTH-1:0]   data_q;
  logic [DEPTH-1:0]              valid_d;
  logic [DEPTH-1:0][WIDTH-1:0]   data_d;

  assign stall    = |stall_in;
  assign load     = clear_in || !stall;
  assign in_ready = load;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    s0_valid = 1'b0;
    s0_data  = data_q[0];
    if (load) begin
      s0_valid = in_valid;
      s0_data  = in_data;
    end
  end

  // Kill only clears the valid bit; the payload still moves so the data path stays simple.
  generate
    if (DEPTH > 1) begin : g_shift
      assign valid_d = {valid_q[DEPTH-2:0], s0_valid} & ~kill_mask;
      assign data_d  = {data_q[DEPTH-2:0], s0_data};
    end else begin : g_single
      assign valid_d = s0_valid & ~kill_mask;
      assign data_d  = s0_data;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
  // NOTE: payload registers are reset too, because out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      data_q    <= '0;
      occupancy <= '0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      occupancy <= popcount(valid_d);
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

`ifdef PIPE_PERF_COUNTERS_EN
  logic [32:0] kill_sum;
  assign kill_sum = {1'b0, kill_cnt} + 33'(popcount(kill_mask));

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      kill_cnt   <= '0;
    end else begin
      if (!load && bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
      kill_cnt <= kill_sum[32] ? 32'hFFFF_FFFF : kill_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_shift_chain.sv
// Directed table-driven bench for pipeline_shift_chain (WIDTH=16, DEPTH=3, STALL_W=8).
module tb_pipeline_shift_chain;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 3;
  localparam int STALL_W = 8;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic [STALL_W-1:0]     stall_in;
  logic                   clear_in;
  logic [DEPTH-1:0]       kill_mask;
  logic                   in_ready;
  logic [DEPTH-1:0]       out_valid;
  logic [DEPTH*WIDTH-1:0] out_data;
  logic [1:0]             occupancy;
`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0]            bubble_cnt;
  logic [31:0]            kill_cnt;
`endif

  pipeline_shift_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .stall_in(stall_in), .clear_in(clear_in), .kill_mask(kill_mask),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_PERF_COUNTERS_EN
    , .bubble_cnt(bubble_cnt), .kill_cnt(kill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] d;
    logic [7:0]  stall;
    logic        clr;
    logic [2:0]  kill;
    logic        e_ready;
    logic [2:0]  e_valid;
    logic [15:0] e_d0;
    logic [15:0] e_d1;
    logic [15:0] e_d2;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vecs[15];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [15:0] d,
                       input logic [7:0] st, input logic clr, input logic [2:0] k);
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; stall_in = st; clear_in = clr; kill_mask = k;
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] v, input logic [15:0] d0,
                               input logic [15:0] d1, input logic [15:0] d2, input logic [1:0] occ);
    check({tag, " valid"}, 64'(out_valid), 64'(v));
    check({tag, " data"},  64'(out_data),  64'({d2, d1, d0}));
    check({tag, " occ"},   64'(occupancy), 64'(occ));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; stall_in = '0; clear_in = 1'b0; kill_mask = '0;

    //          rst iv  data      stall  clr kill   rdy valid   d0        d1        d2        occ
    vecs[0]  = '{1, 0, 16'h0000, 8'h00, 0, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 2'd0};
    vecs[1]  = '{0, 1, 16'h000A, 8'h00, 0, 3'b000, 1, 3'b001, 16'h000A, 16'h0000, 16'h0000, 2'd1};
    vecs[2]  = '{0, 1, 16'h000B, 8'h00, 0, 3'b000, 1, 3'b011, 16'h000B, 16'h000A, 16'h0000, 2'd2};
    vecs[3]  = '{0, 1, 16'h000C, 8'h00, 0, 3'b000, 1, 3'b111, 16'h000C, 16'h000B, 16'h000A, 2'd3};
    vecs[4]  = '{1, 1, 16'h0055, 8'h00, 0, 3'b000, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 2'd0};
    vecs[5]  = '{0, 1, 16'h000A, 8'h00, 0, 3'b000, 1, 3'b001, 16'h000A, 16'h0000, 16'h0000, 2'd1};
    vecs[6]  = '{0, 1, 16'h000B, 8'h04, 0, 3'b000, 0, 3'b010, 16'h000A, 16'h000A, 16'h0000, 2'd1};
    vecs[7]  = '{0, 1, 16'h000B, 8'h04, 0, 3'b000, 0, 3'b100, 16'h000A, 16'h000A, 16'h000A, 2'd1};
    vecs[8]  = '{0, 1, 16'h000B, 8'h00, 0, 3'b000, 1, 3'b001, 16'h000B, 16'h000A, 16'h000A, 2'd1};
    vecs[9]  = '{0, 1, 16'h1234, 8'hFF, 1, 3'b000, 1, 3'b011, 16'h1234, 16'h000B, 16'h000A, 2'd2};
    vecs[10] = '{0, 1, 16'h000D, 8'h00, 0, 3'b000, 1, 3'b111, 16'h000D, 16'h1234, 16'h000B, 2'd3};
    vecs[11] = '{0, 1, 16'h000E, 8'h00, 0, 3'b110, 1, 3'b001, 16'h000E, 16'h000D, 16'h1234, 2'd1};
    vecs[12] = '{0, 1, 16'h000F, 8'h00, 0, 3'b001, 1, 3'b010, 16'h000F, 16'h000E, 16'h000D, 2'd1};
    vecs[13] = '{0, 1, 16'h0077, 8'h01, 0, 3'b100, 0, 3'b000, 16'h000F, 16'h000F, 16'h000E, 2'd0};
    vecs[14] = '{0, 0, 16'h0000, 8'h00, 0, 3'b000, 1, 3'b000, 16'h0000, 16'h000F, 16'h000F, 2'd0};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].stall, vecs[i].clr, vecs[i].kill);
      check($sformatf("vec%0d ready", i), 64'(in_ready), 64'(vecs[i].e_ready));
      @(posedge clk); #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_d0,
                    vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_occ);
    end

    // Mid-stream reset with stall and kill active: everything in flight is lost.
    drive(0, 1, 16'h0021, 8'h00, 0, 3'b000); @(posedge clk);
    drive(0, 1, 16'h0022, 8'h00, 0, 3'b000); @(posedge clk);
    drive(0, 1, 16'h0023, 8'h00, 0, 3'b000); @(posedge clk); #1;
    check_outputs("full", 3'b111, 16'h0023, 16'h0022, 16'h0021, 2'd3);
    drive(0, 1, 16'h0024, 8'hFF, 0, 3'b111); @(posedge clk);
    drive(1, 1, 16'h0025, 8'hFF, 0, 3'b111); @(posedge clk); #1;
    check_outputs("mid_rst", 3'b000, 16'h0000, 16'h0000, 16'h0000, 2'd0);
`ifdef PIPE_PERF_COUNTERS_EN
    check("mid_rst bubble_cnt", 64'(bubble_cnt), 64'd0);
    check("mid_rst kill_cnt",   64'(kill_cnt),   64'd0);
`endif
    // First payload after reset lands in stage 0 one edge later.
    drive(0, 1, 16'h0031, 8'h00, 0, 3'b000); @(posedge clk); #1;
    check_outputs("post_rst", 3'b001, 16'h0031, 16'h0000, 16'h0000, 2'd1);

`ifdef PIPE_PERF_COUNTERS_EN
    // Saturation: preload near max, stall for 3 cycles.
    drive(0, 0, 16'h0000, 8'h00, 0, 3'b000);
    force dut.bubble_cnt = 32'hFFFF_FFFE;
    #1 release dut.bubble_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 16'h0040, 8'h10, 0, 3'b000); @(posedge clk);
    end
    #1;
    check("bubble_cnt sat", 64'(bubble_cnt), 64'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
